rs232c_rx: RTL and testbench

UART receiver, 8N1, the line-side counterpart of the board's RS232C transmitter. It takes the asynchronous serial input, oversamples it 16× with a clock-enable tick, and reassembles bytes LSB-first. Each good byte is presented with a one-cycle `valid` pulse for the downstream consumer (FIFO / command parser). The whole block runs on the system clock; it creates no derived clocks.

---
 rtl/rs232c_pkg.sv | 33 +++
 rtl/rs232c_rx_baud_tick16.sv | 46 ++++
 rtl/rs232c_rx.sv | 164 ++++++++++++++++
 tb/tb_rs232c_rx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rs232c_pkg.sv
// -----------------------------------------------------------------------------
// rs232c_pkg
// Shared definitions for the RS232C receiver (and, later, the transmitter):
//   - rxState_t   : receiver FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3)
//   - OVERSAMPLE  : ticks per bit period
//   - MID_SAMPLE  : tick index inside the start bit where it is re-checked
//   - DIV_WIDTH   : width of the tick divider counter/period
//   - calcDiv()   : tick divider period from clock and baud rate
// -----------------------------------------------------------------------------
package rs232c_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rxState_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;
    localparam int DIV_WIDTH  = 16;

    // Floor of sysClk/(baud*16), never below 1 so the divider always ticks.
    function automatic logic [DIV_WIDTH-1:0] calcDiv(input int sysClk, input int baud);
        int n;
        n = sysClk / (baud * OVERSAMPLE);
        if (n < 1) begin
            n = 1;
        end
        return n[DIV_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/rs232c_rx_baud_tick16.sv
// -----------------------------------------------------------------------------
// baud_tick16
// Free-running clock-enable generator at 16x the baud rate.
// Ports:
//   clk      in  : system clock
//   rst_n    in  : asynchronous active-low reset
//   sync_clr in  : restart the count at 0 (phase-aligns ticks to a start edge)
//   div      in  : tick period in clk cycles (0 is treated as 1)
//   tick     out : one-clk enable, high when the count reaches div-1
// -----------------------------------------------------------------------------
module baud_tick16
    import rs232c_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sync_clr,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] count_q;
    logic [DIV_WIDTH-1:0] count_d;
    logic [DIV_WIDTH-1:0] lastCount;

    // A zero period would never match, so it is folded onto a period of 1.
    assign lastCount = (div == '0) ? '0 : div - 16'd1;
    assign tick      = (count_q == lastCount);

    // Count 0..div-1 and wrap; a start edge restarts the sequence from 0.
    always_comb begin
        count_d = count_q + 16'd1;
        if (sync_clr || tick) begin
            count_d = '0;
        end
    end

    // Divider count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rs232c_rx.sv
// -----------------------------------------------------------------------------
// rs232c_rx
// 8N1 UART receiver, 16x oversampled, LSB first.
// Parameters:
//   sys_clk : system clock frequency in Hz
//   rate    : baud rate in bit/s
// Ports:
//   clk       in  : system clock
//   rst_n     in  : asynchronous active-low reset
//   rxd       in  : serial line, idle high, asynchronous to clk
//   dout      out : last correctly received byte
//   valid     out : one-clk pulse, dout is new in this cycle
//   frame_err out : one-clk pulse when the stop bit is sampled low
//   busy      out : high while a frame is in progress
// -----------------------------------------------------------------------------
module rs232c_rx
    import rs232c_pkg::*;
#(
    parameter int sys_clk = 14000000,
    parameter int rate    = 9600
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] dout,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [DIV_WIDTH-1:0] TICK_DIV = calcDiv(sys_clk, rate);

    logic       rxMeta_q;
    logic       rxs_q;
    logic       rxsPrev_q;
    rxState_t   state_q, state_d;
    logic [3:0] scnt_q, scnt_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic [7:0] sr_q, sr_d;
    logic [7:0] dout_q, dout_d;
    logic       valid_q, valid_d;
    logic       ferr_q, ferr_d;
    logic       tick;
    logic       startEdge;

    // Only a genuine high->low transition starts a frame, so a line stuck
    // low (e.g. after a framing error) cannot retrigger the receiver.
    assign startEdge = (state_q == IDLE) && rxsPrev_q && !rxs_q;

    baud_tick16 u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .sync_clr (startEdge),
        .div      (TICK_DIV),
        .tick     (tick)
    );

    // Two-flop synchronizer plus one delayed copy for edge detection.
    // All three reset to the idle line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxMeta_q  <= 1'b1;
            rxs_q     <= 1'b1;
            rxsPrev_q <= 1'b1;
        end else begin
            rxMeta_q  <= rxd;
            rxs_q     <= rxMeta_q;
            rxsPrev_q <= rxs_q;
        end
    end

    // Next-state logic: the start bit is re-checked at its middle, after
    // which every 16th tick lands in the middle of the following bit.
    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        bcnt_d  = bcnt_q;
        sr_d    = sr_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (startEdge) begin
                    state_d = START;
                    scnt_d  = 4'd0;
                end
            end
            START: begin
                if (tick) begin
                    if (scnt_q == 4'(MID_SAMPLE)) begin
                        if (rxs_q) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            scnt_d  = 4'd0;
                            bcnt_d  = 3'd0;
                        end
                    end else begin
                        scnt_d = scnt_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    scnt_d = scnt_q + 4'd1;
                    if (scnt_q == 4'd15) begin
                        sr_d = {rxs_q, sr_q[7:1]};
                        if (bcnt_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            bcnt_d = bcnt_q + 3'd1;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    scnt_d = scnt_q + 4'd1;
                    if (scnt_q == 4'd15) begin
                        if (rxs_q) begin
                            dout_d  = sr_q;
                            valid_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            scnt_q  <= 4'd0;
            bcnt_q  <= 3'd0;
            sr_q    <= 8'h00;
            dout_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            bcnt_q  <= bcnt_d;
            sr_q    <= sr_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign dout      = dout_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rs232c_rx.sv
// -----------------------------------------------------------------------------
// tb_rs232c_rx
// Directed bench for rs232c_rx. dutA runs at 3200 Hz / 100 baud (2 clk per
// tick, 32 clk per bit); dutB uses the default 14 MHz / 9600 parameters and
// is fed a frame about 2% fast.
// -----------------------------------------------------------------------------
module tb_rs232c_rx;

    logic       clk;
    logic       rst_n;
    logic       rxdA;
    logic       rxdB;
    logic [7:0] doutA;
    logic [7:0] doutB;
    logic       validA;
    logic       validB;
    logic       ferrA;
    logic       ferrB;
    logic       busyA;
    logic       busyB;

    int checkCount = 0;
    int passCount  = 0;

    int cycle          = 0;
    int validCountA    = 0;
    int ferrCountA     = 0;
    int busyCountA     = 0;
    int validCountB    = 0;
    int ferrCountB     = 0;
    int bothHigh       = 0;
    int lastValidCycle = 0;
    int prevValidCycle = 0;
    logic [7:0] lastDataA = 8'h00;
    logic [7:0] prevDataA = 8'h00;

    int snapValid;
    int snapFerr;
    int snapBusy;
    logic [9:0] partial;

    rs232c_rx #(.sys_clk(3200), .rate(100)) dutA (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxdA),
        .dout      (doutA),
        .valid     (validA),
        .frame_err (ferrA),
        .busy      (busyA)
    );

    rs232c_rx dutB (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxdB),
        .dout      (doutB),
        .valid     (validB),
        .frame_err (ferrB),
        .busy      (busyB)
    );

    // 10-time-unit system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse monitor on the falling edge: counts pulses and busy cycles and
    // remembers the bytes and cycle numbers of the last two valid pulses.
    always @(negedge clk) begin
        cycle = cycle + 1;
        if (validA) begin
            validCountA    = validCountA + 1;
            prevDataA      = lastDataA;
            lastDataA      = doutA;
            prevValidCycle = lastValidCycle;
            lastValidCycle = cycle;
        end
        if (ferrA) ferrCountA = ferrCountA + 1;
        if (busyA) busyCountA = busyCountA + 1;
        if (validB) validCountB = validCountB + 1;
        if (ferrB) ferrCountB = ferrCountB + 1;
        if ((validA && ferrA) || (validB && ferrB)) bothHigh = bothHigh + 1;
    end

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount = checkCount + 1;
        if (actual === expected) begin
            passCount = passCount + 1;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bit-bang one 8N1 frame (start, 8 data LSB first, stop) onto rxdA or rxdB.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                                 input int bitClk, input bit useB);
        logic [9:0] frame;
        frame = {stopBit, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (useB) rxdB = frame[i];
            else      rxdA = frame[i];
            waitCycles(bitClk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rxdA  = 1'b1;
        rxdB  = 1'b1;
        waitCycles(3);

        $display("[TB] reset state");
        checkOutput("rst_doutA", {24'h0, doutA}, 32'h00);
        checkOutput("rst_validA", {31'h0, validA}, 32'h0);
        checkOutput("rst_ferrA", {31'h0, ferrA}, 32'h0);
        checkOutput("rst_busyA", {31'h0, busyA}, 32'h0);
        checkOutput("rst_doutB", {24'h0, doutB}, 32'h00);
        rst_n = 1'b1;
        waitCycles(10);

        $display("[TB] single frame 0x55");
        snapValid = validCountA;
        snapFerr  = ferrCountA;
        applyStimulus(8'h55, 1'b1, 32, 1'b0);
        waitCycles(10);
        checkOutput("f55_valid_cnt", 32'(validCountA - snapValid), 32'd1);
        checkOutput("f55_dout", {24'h0, doutA}, 32'h55);
        checkOutput("f55_ferr_cnt", 32'(ferrCountA - snapFerr), 32'd0);
        checkOutput("f55_busy_after", {31'h0, busyA}, 32'h0);

        $display("[TB] back-to-back 0xA3, 0x00");
        snapValid = validCountA;
        applyStimulus(8'hA3, 1'b1, 32, 1'b0);
        applyStimulus(8'h00, 1'b1, 32, 1'b0);
        waitCycles(10);
        checkOutput("b2b_valid_cnt", 32'(validCountA - snapValid), 32'd2);
        checkOutput("b2b_spacing", 32'(lastValidCycle - prevValidCycle), 32'd320);
        checkOutput("b2b_first", {24'h0, prevDataA}, 32'hA3);
        checkOutput("b2b_second", {24'h0, lastDataA}, 32'h00);

        $display("[TB] false start");
        snapValid = validCountA;
        snapFerr  = ferrCountA;
        snapBusy  = busyCountA;
        rxdA = 1'b0;
        waitCycles(8);
        rxdA = 1'b1;
        waitCycles(40);
        checkOutput("fs_valid_cnt", 32'(validCountA - snapValid), 32'd0);
        checkOutput("fs_ferr_cnt", 32'(ferrCountA - snapFerr), 32'd0);
        checkOutput("fs_busy_cycles", 32'(busyCountA - snapBusy), 32'd16);
        checkOutput("fs_busy_after", {31'h0, busyA}, 32'h0);

        $display("[TB] framing error after 0x55");
        snapValid = validCountA;
        applyStimulus(8'h55, 1'b1, 32, 1'b0);
        waitCycles(10);
        checkOutput("fe_pre_valid", 32'(validCountA - snapValid), 32'd1);
        checkOutput("fe_pre_dout", {24'h0, doutA}, 32'h55);
        snapValid = validCountA;
        snapFerr  = ferrCountA;
        applyStimulus(8'hFF, 1'b0, 32, 1'b0);
        waitCycles(10);
        checkOutput("fe_ferr_cnt", 32'(ferrCountA - snapFerr), 32'd1);
        checkOutput("fe_valid_cnt", 32'(validCountA - snapValid), 32'd0);
        checkOutput("fe_dout_kept", {24'h0, doutA}, 32'h55);
        snapValid = validCountA;
        snapFerr  = ferrCountA;
        snapBusy  = busyCountA;
        waitCycles(400);
        checkOutput("low_valid_cnt", 32'(validCountA - snapValid), 32'd0);
        checkOutput("low_ferr_cnt", 32'(ferrCountA - snapFerr), 32'd0);
        checkOutput("low_busy_cycles", 32'(busyCountA - snapBusy), 32'd0);
        rxdA = 1'b1;
        waitCycles(40);

        $display("[TB] reset during data bit 4 of 0x96");
        snapValid = validCountA;
        snapFerr  = ferrCountA;
        partial   = {1'b1, 8'h96, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rxdA = partial[i];
            waitCycles(32);
        end
        rxdA = partial[5];
        waitCycles(16);
        checkOutput("mid_busy_before", {31'h0, busyA}, 32'h1);
        rst_n = 1'b0;
        #2;
        checkOutput("mid_rst_dout", {24'h0, doutA}, 32'h00);
        checkOutput("mid_rst_busy", {31'h0, busyA}, 32'h0);
        waitCycles(4);
        rxdA  = 1'b1;
        rst_n = 1'b1;
        waitCycles(40);
        checkOutput("mid_valid_cnt", 32'(validCountA - snapValid), 32'd0);
        checkOutput("mid_ferr_cnt", 32'(ferrCountA - snapFerr), 32'd0);
        snapValid = validCountA;
        applyStimulus(8'h3C, 1'b1, 32, 1'b0);
        waitCycles(10);
        checkOutput("post_valid_cnt", 32'(validCountA - snapValid), 32'd1);
        checkOutput("post_dout", {24'h0, doutA}, 32'h3C);

        $display("[TB] default parameters, 2%% fast frame 0xC1");
        snapValid = validCountB;
        snapFerr  = ferrCountB;
        applyStimulus(8'hC1, 1'b1, 1430, 1'b1);
        waitCycles(100);
        checkOutput("def_valid_cnt", 32'(validCountB - snapValid), 32'd1);
        checkOutput("def_dout", {24'h0, doutB}, 32'hC1);
        checkOutput("def_ferr_cnt", 32'(ferrCountB - snapFerr), 32'd0);

        checkOutput("valid_ferr_overlap", 32'(bothHigh), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
